// File: rtl/prefetch_block_responder.sv
// prefetch_block_responder: in-order block-fetch queue with fixed memory latency,
// returning address-patterned blocks to the next-line prefetcher fill path.
module prefetch_block_responder #(
    parameter int block_size_byte = 16,
    parameter int mem_latency = 4,
    parameter int queue_depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [31:0]                  req_address,
    output logic                         req_ready,
    output logic [block_size_byte*8-1:0] block,
    output logic [31:0]                  block_address,
    output logic                         block_ready,
    output logic                         busy,
    output logic [7:0]                   drop_count
);
    localparam int ptr_w = $clog2(queue_depth);
    localparam int cnt_w = $clog2(mem_latency + 1);
    localparam int words = block_size_byte / 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [31:0] q_addr [queue_depth];
    logic [queue_depth-1:0] q_valid, push_mask, pop_mask;
    logic [ptr_w-1:0] rd_ptr, wr_ptr;
    logic [31:0] cur_addr, aligned;
    logic [cnt_w-1:0] cnt;
    logic full, empty, dup, push, pop, respond;
    logic [block_size_byte*8-1:0] pattern;

    assign aligned = req_address & ~32'(block_size_byte - 1);
    assign full = &q_valid;
    assign empty = ~|q_valid;
    assign req_ready = !full;
    assign busy = state != IDLE || !empty;
    assign push = req_valid && !full && !dup;
    assign push_mask = push ? queue_depth'(1) << wr_ptr : '0;
    assign pop_mask = pop ? queue_depth'(1) << rd_ptr : '0;

    // The address in service also absorbs duplicates, including during RESP.
    always_comb begin
        dup = state != IDLE && cur_addr == aligned;
        for (int i = 0; i < queue_depth; i++)
            dup = dup | (q_valid[i] && q_addr[i] == aligned);
    end

    always_comb begin
        pattern = '0;
        for (int i = 0; i < words; i++)
            pattern[32*i +: 32] = cur_addr + 32'(4 * i);
    end

    always_comb begin
        pop = state != WAIT && !empty;
        respond = state == WAIT && cnt == cnt_w'(1);
        state_next = pop ? WAIT : respond ? RESP : state == WAIT ? WAIT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q_valid <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
            cur_addr <= '0;
            block <= '0;
            block_address <= '0;
            block_ready <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            block_ready <= respond;
            q_valid <= (q_valid | push_mask) & ~pop_mask;
            if (push) begin
                q_addr[wr_ptr] <= aligned;
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                cur_addr <= q_addr[rd_ptr];
                rd_ptr <= rd_ptr + ptr_w'(1);
                cnt <= cnt_w'(mem_latency);
            end else if (state == WAIT) begin
                cnt <= cnt - cnt_w'(1);
            end
            if (respond) begin
                block <= pattern;
                block_address <= cur_addr;
            end
            if (req_valid && full && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_prefetch_block_responder.sv
// tb_prefetch_block_responder: directed and random stimulus against a timestamped
// transaction model of the responder (pending queue plus one request in service).
module tb_prefetch_block_responder;
    localparam int bs = 16, lat = 4, qd = 4;

    logic clk = 1'b0;
    logic rst, req_valid, req_ready, block_ready, busy;
    logic [31:0] req_address, block_address;
    logic [bs*8-1:0] block;
    logic [7:0] drop_count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    prefetch_block_responder #(.block_size_byte(bs), .mem_latency(lat), .queue_depth(qd)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_address(req_address),
        .req_ready(req_ready), .block(block), .block_address(block_address),
        .block_ready(block_ready), .busy(busy), .drop_count(drop_count)
    );

    logic [31:0] m_q[$];
    bit m_svc;
    logic [31:0] m_addr;
    int m_ready_edge, edge_n = 0;
    bit e_ready;
    logic [31:0] e_baddr;
    logic [bs*8-1:0] e_block;
    int e_drops;
    logic [31:0] resp_a[$];
    int resp_t[$];

    function automatic logic [bs*8-1:0] fill(input logic [31:0] a);
        logic [bs*8-1:0] r;
        for (int i = 0; i < bs / 4; i++) r[32*i +: 32] = a + 32'(4 * i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [bs*8-1:0] obs, input logic [bs*8-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A popped request becomes visible lat edges later; the slot frees one edge after that.
    task automatic model_edge(input bit v, input logic [31:0] a);
        logic [31:0] al;
        bit full, dup;
        al = a & ~32'(bs - 1);
        full = m_q.size() == qd;
        dup = m_svc && m_addr == al;
        foreach (m_q[i]) if (m_q[i] == al) dup = 1'b1;
        e_ready = 1'b0;
        if (m_svc && edge_n == m_ready_edge) begin
            e_ready = 1'b1;
            e_baddr = m_addr;
            e_block = fill(m_addr);
        end
        if (m_svc && edge_n == m_ready_edge + 1) m_svc = 1'b0;
        if (!m_svc && m_q.size() > 0) begin
            m_addr = m_q.pop_front();
            m_svc = 1'b1;
            m_ready_edge = edge_n + lat;
        end
        if (v && !full && !dup) m_q.push_back(al);
        if (v && full && e_drops < 255) e_drops++;
        edge_n++;
    endtask

    task automatic check_all();
        chk("block_ready", block_ready, e_ready);
        chk("block_address", block_address, e_baddr);
        chk("block", block, e_block);
        chk("req_ready", req_ready, m_q.size() != qd);
        chk("busy", busy, m_svc || m_q.size() > 0);
        chk("drop_count", drop_count, e_drops);
    endtask

    task automatic step(input bit v, input logic [31:0] a);
        req_valid = v;
        req_address = a;
        @(posedge clk);
        model_edge(v, a);
        #1;
        check_all();
        if (block_ready) begin
            resp_a.push_back(block_address);
            resp_t.push_back(edge_n);
        end
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_address = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_q.delete();
        m_svc = 1'b0;
        e_ready = 1'b0;
        e_baddr = '0;
        e_block = '0;
        e_drops = 0;
        check_all();
        resp_a.delete();
        resp_t.delete();
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        do begin
            step(1'b0, '0);
            n++;
        end while (!block_ready && n < max);
        chk("wait_bound", block_ready, 1);
    endtask

    initial begin
        int n;
        do_reset();
        chk("reset_block", block, 0);
        chk("reset_drop", drop_count, 0);

        step(1'b1, 32'h0000_1234);
        wait_ready(20, n);
        chk("latency", n, 5);
        chk("single_addr", block_address, 32'h0000_1230);
        chk("single_block", block, 128'h0000123C_00001238_00001234_00001230);
        repeat (8) step(1'b0, '0);
        chk("single_pulse", resp_a.size(), 1);

        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + 32'(16 * i));
        chk("burst_drop", drop_count, 1);
        repeat (30) step(1'b0, '0);
        chk("burst_count", resp_a.size(), 5);
        for (int i = 0; i < resp_a.size(); i++) chk("burst_order", resp_a[i], 32'h100 + 32'(16 * i));
        for (int i = 1; i < resp_t.size(); i++) chk("burst_spacing", resp_t[i] - resp_t[i-1], 5);
        chk("burst_idle", busy, 0);

        do_reset();
        step(1'b1, 32'h200);
        step(1'b1, 32'h204);
        step(1'b0, '0);
        step(1'b1, 32'h20F);
        repeat (12) step(1'b0, '0);
        chk("dup_count", resp_a.size(), 1);
        chk("dup_addr", resp_a[0], 32'h200);
        chk("dup_drop", drop_count, 0);

        do_reset();
        step(1'b1, 32'hFFFF_FFF8);
        wait_ready(20, n);
        chk("wrap_addr", block_address, 32'hFFFF_FFF0);
        chk("wrap_block", block, 128'hFFFFFFFC_FFFFFFF8_FFFFFFF4_FFFFFFF0);

        do_reset();
        step(1'b1, 32'h300);
        step(1'b1, 32'h310);
        step(1'b1, 32'h320);
        do_reset();
        repeat (10) step(1'b0, '0);
        chk("rst_no_resp", resp_a.size(), 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_drop", drop_count, 0);
        step(1'b1, 32'h400);
        wait_ready(20, n);
        chk("rst_latency", n, 5);
        chk("rst_addr", block_address, 32'h400);

        do_reset();
        for (int i = 0; i < 400; i++) step(1'b1, 32'h1_0000 + 32'(16 * i));
        chk("saturate", drop_count, 255);

        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, 32'h2000 + 32'($urandom_range(0, 127)));
        repeat (40) step(1'b0, '0);
        chk("random_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
